dsp_mac_sequencer: RTL and testbench
====================================

Name: dsp_mac_sequencer

Overview:
- Upstream controller for the DSP48A1 slice, configured with all pipeline registers enabled (A0/A1/B0/B1/M/P/OPMODE = 1) and all CE tied high.
- Accepts a job of N signed 18x18 operand pairs over a valid/ready stream and issues them to the slice's A/B ports.
- Drives the slice's OPMODE so that P = sum of A*B over the job.
- Captures P after the pipeline drains and presents a one-cycle result strobe.
- The slice's C, D, PCIN and BCIN are tied to 0 at top level. B_INPUT is "DIRECT".

Parameters:
- ISSUE_TO_P, 4, edges from sequencer-registered A/B to P valid: A0, A1, M, P.
- OPMODE_DLY, 2, cycles OPMODE tag lags its operands so the slice's OPMODE register lines up with the M->P stage.
- LEN_W, 8, width of job length.

Ports:
- CLK  in  1  clock; all logic rising-edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  begin job; sampled only in IDLE.
- len  in  LEN_W  number of operand pairs; captured with start.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer accepts pair this cycle.
- a_in  in  18  signed operand A.
- b_in  in  18  signed operand B.
- dsp_A  out  18  to slice A, registered.
- dsp_B  out  18  to slice B, registered.
- dsp_OPMODE  out  8  to slice OPMODE, registered.
- dsp_CARRYIN  out  1  to slice CARRYIN, constant 0.
- dsp_P  in  48  from slice P.
- result  out  48  accumulated sum, held until next capture.
- result_valid  out  1  one-cycle strobe.
- busy  out  1  high in RUN and DRAIN.

Behaviour:
- Reset values: in_ready=0, dsp_A=0, dsp_B=0, dsp_OPMODE=8'b0000_1000 (HOLD: X=0, Z=P), result=0, result_valid=0, busy=0.
- Reset also clears the OPMODE delay line to HOLD and forces IDLE. It takes effect mid-job: no result_valid for the aborted job.
- Slot encodings, one tag per cycle, registered alongside dsp_A/dsp_B:
  - FIRST = 8'b0000_0001: P = M, clears the accumulator.
  - ACC = 8'b0000_1001: P = P + M.
  - HOLD = 8'b0000_1000: P = P + 0.
- On a handshake edge, dsp_A/dsp_B <= a_in/b_in. On non-handshake edges they <= 0 and the tag is HOLD.
- The first handshake of a job is tagged FIRST; later handshakes are tagged ACC.
- Tags pass through an OPMODE_DLY-deep shift register; dsp_OPMODE is its output. Handshake at edge e therefore gives OPMODE valid after e+OPMODE_DLY and the P update at edge e+ISSUE_TO_P.
- FSM:
  - IDLE: in_ready=0. start & len!=0 -> RUN, load cnt=len. start & len==0 -> stays IDLE, result<=0, and result_valid pulses the next cycle.
  - RUN: in_ready=1. Each handshake decrements cnt. The handshake with cnt==1 -> DRAIN, with in_ready low from the next cycle. in_valid low inserts a bubble (HOLD) and leaves the sum unchanged.
  - DRAIN: in_ready=0. A wait counter is loaded with ISSUE_TO_P at DRAIN entry (last-handshake edge e). At edge e+ISSUE_TO_P+1, result<=dsp_P, result_valid=1 for exactly one cycle, -> IDLE.
- Timing: last handshake to result_valid is ISSUE_TO_P+1 = 5 cycles. Back-to-back start is accepted the cycle after result_valid.
- start while busy is ignored. len is not re-sampled during a job.
- Arithmetic: the 36-bit signed product is sign-extended to 48 bits inside the slice. The sequencer does no arithmetic and passes dsp_P unmodified.
- Range: max |sum| = 255*2^34 < 2^47, so no overflow for LEN_W=8.
- Bubbles may occur anywhere in RUN; FIRST is always attached to the first accepted pair, even if preceded by idle cycles.

Test Plan:
- Single tap: start, len=1, pair (3020, 3) -> result_valid 5 cycles after the handshake, result=9060; busy low the cycle after.
- Four taps streamed continuously: (1,2),(3,4),(5,6),(7,8) -> result=100; dsp_OPMODE sequence at the slice is FIRST, ACC, ACC, ACC.
- Same four taps with in_valid low for 1 cycle between each pair and 3 cycles before the first -> result=100; HOLD slots appear in dsp_OPMODE.
- Signed: (-2,3), (5,5), (-131072,1) -> result = 19-131072 = -131053, sign-extended 48'hFFFF_FFFE_0013.
- Back-to-back jobs: job1 (10,10) -> 100; start the cycle after result_valid, job2 (1,1) -> 1 (not 101). Also len=0 -> result=0, strobe 1 cycle after start, no in_ready.
- RST asserted during RUN after 2 of 4 handshakes -> no result_valid, outputs at reset values. A following job (2,2) gives result=4.

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// rtl/dsp_mac_sequencer.sv - issues signed 18x18 operand pairs to a fully pipelined DSP48A1 and captures the accumulated P
module dsp_mac_sequencer #(
  parameter int ISSUE_TO_P = 4,
  parameter int OPMODE_DLY = 2,
  parameter int LEN_W      = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [17:0]       a_in,
  input  logic [17:0]       b_in,
  output logic [17:0]       dsp_A,
  output logic [17:0]       dsp_B,
  output logic [7:0]        dsp_OPMODE,
  output logic              dsp_CARRYIN,
  input  logic [47:0]       dsp_P,
  output logic [47:0]       result,
  output logic              result_valid,
  output logic              busy
);

  localparam logic [7:0] OP_FIRST = 8'b0000_0001;  // X=M, Z=0
  localparam logic [7:0] OP_ACC   = 8'b0000_1001;  // X=M, Z=P
  localparam logic [7:0] OP_HOLD  = 8'b0000_1000;  // X=0, Z=P

  localparam int WAIT_W = $clog2(ISSUE_TO_P + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  logic [LEN_W-1:0]  r_cnt;
  logic [WAIT_W-1:0] r_wait;
  logic              r_first;
  logic              r_in_ready;
  logic              r_busy;
  logic [17:0]       r_dsp_a;
  logic [17:0]       r_dsp_b;
  logic [7:0]        r_tag;
  logic [7:0]        r_dly [OPMODE_DLY];
  logic [47:0]       r_result;
  logic              r_result_valid;

  logic              w_hs;

  // in_ready is only ever high in RUN, so it alone qualifies the handshake
  assign w_hs = r_in_ready & in_valid;

  assign in_ready     = r_in_ready;
  assign busy         = r_busy;
  assign dsp_A        = r_dsp_a;
  assign dsp_B        = r_dsp_b;
  assign dsp_OPMODE   = r_dly[OPMODE_DLY-1];
  assign dsp_CARRYIN  = 1'b0;
  assign result       = r_result;
  assign result_valid = r_result_valid;

  // Operand issue and tag generation; the tag then trails its operands so the slice's
  // OPMODE register lines up with the M->P stage of the same pair
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dsp_a <= '0;
      r_dsp_b <= '0;
      r_tag   <= OP_HOLD;
      for (int i = 0; i < OPMODE_DLY; i++) begin
        r_dly[i] <= OP_HOLD;
      end
    end else begin
      if (w_hs) begin
        r_dsp_a <= a_in;
        r_dsp_b <= b_in;
        r_tag   <= r_first ? OP_FIRST : OP_ACC;
      end else begin
        r_dsp_a <= '0;
        r_dsp_b <= '0;
        r_tag   <= OP_HOLD;
      end
      r_dly[0] <= r_tag;
      for (int i = 1; i < OPMODE_DLY; i++) begin
        r_dly[i] <= r_dly[i-1];
      end
    end
  end

  // Job control FSM: count accepted pairs, wait for the pipeline to drain, capture P
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_wait         <= '0;
      r_first        <= 1'b0;
      r_in_ready     <= 1'b0;
      r_busy         <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              r_state    <= S_RUN;
              r_cnt      <= len;
              r_first    <= 1'b1;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b1;
            end else begin
              // empty job: the sum is zero and no slice traffic is needed
              r_result       <= '0;
              r_result_valid <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_hs) begin
            r_first <= 1'b0;
            r_cnt   <= r_cnt - LEN_W'(1);
            if (r_cnt == LEN_W'(1)) begin
              r_state    <= S_DRAIN;
              r_in_ready <= 1'b0;
              r_wait     <= WAIT_W'(ISSUE_TO_P);
            end
          end
        end
        S_DRAIN: begin
          // counter hits zero on the edge P takes the last product; sample one edge later
          if (r_wait == '0) begin
            r_result       <= dsp_P;
            r_result_valid <= 1'b1;
            r_busy         <= 1'b0;
            r_state        <= S_IDLE;
          end else begin
            r_wait <= r_wait - WAIT_W'(1);
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb/tb_dsp_mac_sequencer.sv - scoreboard bench for dsp_mac_sequencer with a DSP48A1 pipeline model
module tb_dsp_mac_sequencer;

  localparam logic [7:0] OP_FIRST = 8'b0000_0001;
  localparam logic [7:0] OP_ACC   = 8'b0000_1001;
  localparam logic [7:0] OP_HOLD  = 8'b0000_1000;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] a_in;
  logic [17:0] b_in;
  logic [17:0] dsp_A;
  logic [17:0] dsp_B;
  logic [7:0]  dsp_OPMODE;
  logic        dsp_CARRYIN;
  logic [47:0] dsp_P;
  logic [47:0] result;
  logic        result_valid;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rv_total = 0;
  int n_pushed = 0;
  int hs_edge  = 0;
  int start_edge = 0;
  bit log_en = 0;
  logic [47:0] exp_q [$];
  logic [7:0]  op_log [$];

  dsp_mac_sequencer #(.ISSUE_TO_P(4), .OPMODE_DLY(2), .LEN_W(8)) dut (
    .CLK(CLK), .RST(RST), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_OPMODE(dsp_OPMODE), .dsp_CARRYIN(dsp_CARRYIN),
    .dsp_P(dsp_P), .result(result), .result_valid(result_valid), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // DSP48A1 model: A0/A1/B0/B1, M, OPMODE and P registers enabled
  logic signed [17:0] s_a0, s_a1, s_b0, s_b1;
  logic signed [35:0] s_m;
  logic [7:0]         s_opm;
  logic [47:0]        s_p;
  logic [47:0]        s_x, s_z;

  always_comb begin
    s_x = 48'd0;
    s_z = 48'd0;
    if (s_opm[1:0] == 2'b01) s_x = {{12{s_m[35]}}, s_m};
    if (s_opm[3:2] == 2'b10) s_z = s_p;
  end

  always @(posedge CLK) begin
    s_a0  <= dsp_A;
    s_a1  <= s_a0;
    s_b0  <= dsp_B;
    s_b1  <= s_b0;
    s_m   <= s_a1 * s_b1;
    s_opm <= dsp_OPMODE;
    s_p   <= s_z + s_x + {47'd0, dsp_CARRYIN};
  end

  assign dsp_P = s_p;

  always @(negedge CLK) begin
    if (result_valid) rv_total <= rv_total + 1;
    if (log_en) op_log.push_back(dsp_OPMODE);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input int n);
    start = 1'b1;
    len = n[7:0];
    @(posedge CLK);
    #1;
    start_edge = cyc;
    start = 1'b0;
  endtask

  task automatic send_pair(input int a, input int b, input int idle);
    bit ok;
    ok = 0;
    if (idle > 0) begin
      in_valid = 1'b0;
      repeat (idle) begin
        @(posedge CLK);
        #1;
      end
    end
    a_in = a[17:0];
    b_in = b[17:0];
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge CLK);
      if (in_ready) begin
        @(posedge CLK);
        #1;
        hs_edge = cyc;
        ok = 1;
      end else begin
        @(posedge CLK);
        #1;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL handshake: got no in_ready within 20 cycles, required a handshake");
    end
  endtask

  task automatic wait_result(input int max, output int edge_at, output bit got);
    got = 0;
    edge_at = -1;
    for (int k = 0; k < max && !got; k++) begin
      @(negedge CLK);
      if (result_valid) begin
        got = 1;
        edge_at = cyc;
      end
    end
  endtask

  task automatic check_result(input string name, input int edge_at, input bit got, input int lat);
    logic [47:0] e;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s_strobe: result_valid never seen, required a strobe", name);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    if (lat >= 0) begin
      total++;
      if (edge_at - hs_edge !== lat) begin
        bad++;
        $display("FAIL %s_latency: got %0d cycles, required %0d", name, edge_at - hs_edge, lat);
      end
    end
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s_scoreboard: result %h with empty queue", name, result);
      return;
    end
    e = exp_q.pop_front();
    if (result !== e) begin
      bad++;
      $display("FAIL %s_value: got %h, required %h", name, result, e);
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    total++; if (in_ready !== 1'b0)       begin bad++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
    total++; if (dsp_A !== 18'd0)         begin bad++; $display("FAIL rst_dsp_A: got %h, required 0", dsp_A); end
    total++; if (dsp_B !== 18'd0)         begin bad++; $display("FAIL rst_dsp_B: got %h, required 0", dsp_B); end
    total++; if (dsp_OPMODE !== OP_HOLD)  begin bad++; $display("FAIL rst_opmode: got %b, required %b", dsp_OPMODE, OP_HOLD); end
    total++; if (dsp_CARRYIN !== 1'b0)    begin bad++; $display("FAIL rst_carryin: got %b, required 0", dsp_CARRYIN); end
    total++; if (result !== 48'd0)        begin bad++; $display("FAIL rst_result: got %h, required 0", result); end
    total++; if (result_valid !== 1'b0)   begin bad++; $display("FAIL rst_result_valid: got %b, required 0", result_valid); end
    total++; if (busy !== 1'b0)           begin bad++; $display("FAIL rst_busy: got %b, required 0", busy); end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (8) begin @(posedge CLK); #1; end
  endtask

  task automatic test_single;
    int ed; bit got;
    do_start(1);
    exp_q.push_back(48'd9060); n_pushed++;
    send_pair(3020, 3, 0);
    in_valid = 1'b0;
    wait_result(20, ed, got);
    check_result("single", ed, got, 5);
    @(negedge CLK);
    total++; if (busy !== 1'b0)         begin bad++; $display("FAIL single_busy_after: got %b, required 0", busy); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL single_strobe_width: got %b, required 0", result_valid); end
    total++; if (result !== 48'd9060)   begin bad++; $display("FAIL single_held: got %h, required %h", result, 48'd9060); end
  endtask

  task automatic run_four(input string name, input int lead, input int gap, input int holds_req);
    int ed; bit got; int first_i; int last_i; int holds;
    logic [7:0] nz [$];
    op_log.delete();
    log_en = 1;
    do_start(4);
    exp_q.push_back(48'd100); n_pushed++;
    send_pair(1, 2, lead);
    send_pair(3, 4, gap);
    send_pair(5, 6, gap);
    send_pair(7, 8, gap);
    in_valid = 1'b0;
    wait_result(20, ed, got);
    check_result(name, ed, got, 5);
    log_en = 0;
    first_i = -1; last_i = -1; holds = 0;
    foreach (op_log[i]) begin
      if (op_log[i] !== OP_HOLD) begin
        nz.push_back(op_log[i]);
        if (first_i < 0) first_i = i;
        last_i = i;
      end
    end
    for (int i = first_i + 1; i < last_i; i++) begin
      if (op_log[i] === OP_HOLD) holds++;
    end
    total++;
    if (nz.size() !== 4) begin
      bad++;
      $display("FAIL %s_op_count: got %0d non-HOLD slots, required 4", name, nz.size());
    end else begin
      total++;
      if (nz[0] !== OP_FIRST || nz[1] !== OP_ACC || nz[2] !== OP_ACC || nz[3] !== OP_ACC) begin
        bad++;
        $display("FAIL %s_op_seq: got %b %b %b %b, required FIRST ACC ACC ACC", name, nz[0], nz[1], nz[2], nz[3]);
      end
    end
    total++;
    if (holds !== holds_req) begin
      bad++;
      $display("FAIL %s_op_holds: got %0d interior HOLD slots, required %0d", name, holds, holds_req);
    end
  endtask

  task automatic test_signed;
    int ed; bit got;
    do_start(3);
    exp_q.push_back(48'hFFFF_FFFE_0013); n_pushed++;
    send_pair(-2, 3, 0);
    send_pair(5, 5, 0);
    send_pair(-131072, 1, 0);
    in_valid = 1'b0;
    wait_result(20, ed, got);
    check_result("signed", ed, got, 5);
  endtask

  task automatic test_back_to_back;
    int ed; bit got;
    do_start(1);
    exp_q.push_back(48'd100); n_pushed++;
    send_pair(10, 10, 0);
    in_valid = 1'b0;
    wait_result(20, ed, got);
    check_result("b2b_job1", ed, got, 5);
    do_start(1);
    total++;
    if (start_edge !== ed + 1) begin
      bad++;
      $display("FAIL b2b_start_edge: got edge %0d, required %0d", start_edge, ed + 1);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accepted: in_ready got %b, required 1", in_ready);
    end
    exp_q.push_back(48'd1); n_pushed++;
    send_pair(1, 1, 0);
    in_valid = 1'b0;
    wait_result(20, ed, got);
    check_result("b2b_job2", ed, got, 5);
  endtask

  task automatic test_reset_mid_job;
    int ed; bit got; int rv_before;
    do_start(4);
    send_pair(1, 1, 0);
    send_pair(2, 2, 0);
    in_valid = 1'b0;
    rv_before = rv_total;
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    total++; if (busy !== 1'b0)          begin bad++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    total++; if (in_ready !== 1'b0)      begin bad++; $display("FAIL midrst_in_ready: got %b, required 0", in_ready); end
    total++; if (result !== 48'd0)       begin bad++; $display("FAIL midrst_result: got %h, required 0", result); end
    total++; if (dsp_OPMODE !== OP_HOLD) begin bad++; $display("FAIL midrst_opmode: got %b, required %b", dsp_OPMODE, OP_HOLD); end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (12) begin @(posedge CLK); #1; end
    total++;
    if (rv_total !== rv_before) begin
      bad++;
      $display("FAIL midrst_no_strobe: got %0d strobes, required 0", rv_total - rv_before);
    end
    do_start(1);
    exp_q.push_back(48'd4); n_pushed++;
    send_pair(2, 2, 0);
    in_valid = 1'b0;
    wait_result(20, ed, got);
    check_result("after_rst", ed, got, 5);
  endtask

  task automatic test_len_zero;
    int ed; bit got; bit saw_ready;
    saw_ready = 0;
    #2;
    do_start(0);
    exp_q.push_back(48'd0); n_pushed++;
    @(negedge CLK);
    got = result_valid;
    ed = cyc;
    if (in_ready) saw_ready = 1;
    check_result("len0", ed, got, -1);
    total++;
    if (ed !== start_edge) begin
      bad++;
      $display("FAIL len0_timing: strobe at edge %0d, required %0d", ed, start_edge);
    end
    repeat (4) begin
      @(negedge CLK);
      if (in_ready) saw_ready = 1;
    end
    total++;
    if (saw_ready !== 1'b0) begin
      bad++;
      $display("FAIL len0_in_ready: got in_ready high, required low");
    end
  endtask

  initial begin
    RST = 1'b0;
    start = 1'b0;
    len = 8'd0;
    in_valid = 1'b0;
    a_in = 18'd0;
    b_in = 18'd0;
    @(posedge CLK);
    #1;
    test_reset();
    test_single();
    run_four("four", 0, 0, 0);
    run_four("bubble", 3, 1, 3);
    test_signed();
    test_back_to_back();
    test_reset_mid_job();
    test_len_zero();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    total++;
    if (rv_total !== n_pushed) begin
      bad++;
      $display("FAIL strobe_count: got %0d strobes, required %0d", rv_total, n_pushed);
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
